bus_ctrl_seq: RTL and testbench

//  Microcode sequencer: the bus initiator driving every register's load/enable strobes.

---
 rtl/bus_ctrl_seq.sv | 165 ++++++++++++++++
 tb/tb_bus_ctrl_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_ctrl_seq.sv
// Microcode sequencer: T-step counter plus opcode x step decode into bus enable/load strobes.
// Optional FLAGS_EN macro enables conditional jumps (JC/JZ) and the flag-load strobe (fi).
module bus_ctrl_seq #(
  parameter int N_STEPS = 5
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [3:0] opcode,
  input  logic       flag_c,
  input  logic       flag_z,
  output logic [2:0] step,
  output logic       co,
  output logic       ro,
  output logic       io,
  output logic       eo,
  output logic       ao,
  output logic       mi,
  output logic       ri,
  output logic       ii,
  output logic       ai,
  output logic       bi,
  output logic       oi,
  output logic       j,
  output logic       ce,
  output logic       su,
  output logic       fi,
  output logic       hlt
);

  // step | meaning
  // 0    | fetch: PC -> MAR
  // 1    | fetch: RAM -> IR, PC increment
  // 2    | execute 1 (HLT freezes here)
  // 3    | execute 2
  // 4    | execute 3
  // 5..7 | unused unless N_STEPS > 5; no microcode, all strobes 0

`ifdef FLAGS_EN
  localparam logic FLAGS_ON = 1'b1;
`else
  localparam logic FLAGS_ON = 1'b0;
`endif

  localparam logic [2:0] LAST_STEP = 3'(N_STEPS - 1);
  localparam logic [3:0] NUM_STEPS = 4'(N_STEPS);

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [2:0] step_nxt;
  logic       step_valid;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) step <= 3'd0;
    else       step <= step_nxt;
  end

  // hlt is itself gated by clear, so the freeze can only be broken by reset
  always_comb begin
    step_nxt = step;
    if (!hlt) begin
      if (step == LAST_STEP) step_nxt = 3'd0;
      else                   step_nxt = step + 3'd1;
    end
  end

  assign step_valid = ({1'b0, step} < NUM_STEPS);

  always_comb begin
    co  = 1'b0;
    ro  = 1'b0;
    io  = 1'b0;
    eo  = 1'b0;
    ao  = 1'b0;
    mi  = 1'b0;
    ri  = 1'b0;
    ii  = 1'b0;
    ai  = 1'b0;
    bi  = 1'b0;
    oi  = 1'b0;
    j   = 1'b0;
    ce  = 1'b0;
    su  = 1'b0;
    fi  = 1'b0;
    hlt = 1'b0;
    if (!clear && step_valid) begin
      case (step)
        3'd0: begin
          co = 1'b1;
          mi = 1'b1;
        end
        3'd1: begin
          ro = 1'b1;
          ii = 1'b1;
          ce = 1'b1;
        end
        3'd2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              io = 1'b1;
              mi = 1'b1;
            end
            OP_LDI: begin
              io = 1'b1;
              ai = 1'b1;
            end
            OP_JMP: begin
              io = 1'b1;
              j  = 1'b1;
            end
            OP_JC: begin
              io = FLAGS_ON & flag_c;
              j  = FLAGS_ON & flag_c;
            end
            OP_JZ: begin
              io = FLAGS_ON & flag_z;
              j  = FLAGS_ON & flag_z;
            end
            OP_OUT: begin
              ao = 1'b1;
              oi = 1'b1;
            end
            OP_HLT: hlt = 1'b1;
            default: ;
          endcase
        end
        3'd3: begin
          case (opcode)
            OP_LDA: begin
              ro = 1'b1;
              ai = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ro = 1'b1;
              bi = 1'b1;
            end
            OP_STA: begin
              ao = 1'b1;
              ri = 1'b1;
            end
            default: ;
          endcase
        end
        3'd4: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            eo = 1'b1;
            ai = 1'b1;
            su = (opcode == OP_SUB);
            fi = FLAGS_ON;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_ctrl_seq.sv
// Self-checking bench for bus_ctrl_seq: vector table, corner sequences, random run vs. model.
// Instantiates N_STEPS=5 and N_STEPS=3 variants sharing the same inputs.
module tb_bus_ctrl_seq;

`ifdef FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  localparam logic [15:0] CO = 16'h8000, RO = 16'h4000, IO = 16'h2000, EO = 16'h1000;
  localparam logic [15:0] AO = 16'h0800, MI = 16'h0400, RI = 16'h0200, II = 16'h0100;
  localparam logic [15:0] AI = 16'h0080, BI = 16'h0040, OI = 16'h0020, JJ = 16'h0010;
  localparam logic [15:0] CE = 16'h0008, SU = 16'h0004, FI = 16'h0002, HL = 16'h0001;
  localparam logic [15:0] DRV_MASK  = 16'hF800;
  localparam logic [15:0] LOAD_MASK = 16'h07F0;
  localparam logic [15:0] FI_E = FLAGS_ON ? FI : 16'h0000;
  localparam logic [15:0] JC_E = FLAGS_ON ? (IO | JJ) : 16'h0000;

  logic       clk = 1'b0;
  logic       clear;
  logic [3:0] opcode;
  logic       flag_c, flag_z;

  logic [2:0] step5, step3;
  logic co5, ro5, io5, eo5, ao5, mi5, ri5, ii5, ai5, bi5, oi5, j5, ce5, su5, fi5, hlt5;
  logic co3, ro3, io3, eo3, ao3, mi3, ri3, ii3, ai3, bi3, oi3, j3, ce3, su3, fi3, hlt3;
  logic [15:0] w5, w3;

  always #5 clk = ~clk;

  bus_ctrl_seq #(.N_STEPS(5)) dut5 (
    .clk(clk), .clear(clear), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
    .step(step5), .co(co5), .ro(ro5), .io(io5), .eo(eo5), .ao(ao5),
    .mi(mi5), .ri(ri5), .ii(ii5), .ai(ai5), .bi(bi5), .oi(oi5), .j(j5),
    .ce(ce5), .su(su5), .fi(fi5), .hlt(hlt5)
  );

  bus_ctrl_seq #(.N_STEPS(3)) dut3 (
    .clk(clk), .clear(clear), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
    .step(step3), .co(co3), .ro(ro3), .io(io3), .eo(eo3), .ao(ao3),
    .mi(mi3), .ri(ri3), .ii(ii3), .ai(ai3), .bi(bi3), .oi(oi3), .j(j3),
    .ce(ce3), .su(su3), .fi(fi3), .hlt(hlt3)
  );

  assign w5 = {co5, ro5, io5, eo5, ao5, mi5, ri5, ii5, ai5, bi5, oi5, j5, ce5, su5, fi5, hlt5};
  assign w3 = {co3, ro3, io3, eo3, ao3, mi3, ri3, ii3, ai3, bi3, oi3, j3, ce3, su3, fi3, hlt3};

  int n_checks = 0;
  int n_errors = 0;
  int ms5 = 0;
  int ms3 = 0;

  // execute microcode per opcode for T2..T4, straight from the instruction list
  logic [15:0] ex_tab [16][3];

  typedef struct {
    logic [3:0]  op;
    logic        fc;
    logic        fz;
    logic [2:0]  st;
    logic [15:0] w;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_word(input logic [3:0] op, input logic fc, input logic fz,
                                           input int st, input int ns, input logic clr);
    logic [15:0] w;
    if (clr || st >= ns || st > 4) return 16'h0000;
    if (st == 0) return CO | MI;
    if (st == 1) return RO | II | CE;
    w = ex_tab[op][st-2];
    if (op == 4'h7 && st == 2) w = (FLAGS_ON && fc) ? (IO | JJ) : 16'h0000;
    if (op == 4'h8 && st == 2) w = (FLAGS_ON && fz) ? (IO | JJ) : 16'h0000;
    if (!FLAGS_ON) w = w & ~FI;
    return w;
  endfunction

  function automatic int step_next(input int st, input logic [3:0] op, input int ns);
    if (op == 4'hF && st == 2) return st;
    return (st == ns - 1) ? 0 : st + 1;
  endfunction

  task automatic cyc();
    if (clear) begin
      ms5 = 0;
      ms3 = 0;
    end else begin
      ms5 = step_next(ms5, opcode, 5);
      ms3 = step_next(ms3, opcode, 3);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_clear(input logic v);
    clear = v;
    if (v) begin
      ms5 = 0;
      ms3 = 0;
    end
  endtask

  task automatic check_model(input string tag);
    #2;
    chk({tag, "_step5"}, {13'd0, step5}, 16'(ms5));
    chk({tag, "_word5"}, w5, ref_word(opcode, flag_c, flag_z, ms5, 5, clear));
    chk({tag, "_step3"}, {13'd0, step3}, 16'(ms3));
    chk({tag, "_word3"}, w3, ref_word(opcode, flag_c, flag_z, ms3, 3, clear));
    chk({tag, "_drv5"},  16'($countones(w5 & DRV_MASK) <= 1), 16'd1);
    chk({tag, "_load5"}, 16'($countones(w5 & LOAD_MASK) <= 1), 16'd1);
    chk({tag, "_drv3"},  16'($countones(w3 & DRV_MASK) <= 1), 16'd1);
    chk({tag, "_load3"}, 16'($countones(w3 & LOAD_MASK) <= 1), 16'd1);
  endtask

  task automatic do_reset();
    set_clear(1'b1);
    cyc();
    set_clear(1'b0);
  endtask

  initial begin
    for (int o = 0; o < 16; o++)
      for (int s = 0; s < 3; s++) ex_tab[o][s] = 16'h0000;
    ex_tab[1][0] = IO | MI;  ex_tab[1][1] = RO | AI;
    ex_tab[2][0] = IO | MI;  ex_tab[2][1] = RO | BI;  ex_tab[2][2] = EO | AI | FI;
    ex_tab[3][0] = IO | MI;  ex_tab[3][1] = RO | BI;  ex_tab[3][2] = EO | AI | SU | FI;
    ex_tab[4][0] = IO | MI;  ex_tab[4][1] = AO | RI;
    ex_tab[5][0] = IO | AI;
    ex_tab[6][0] = IO | JJ;
    ex_tab[14][0] = AO | OI;
    ex_tab[15][0] = HL;

    // continuous instruction stream starting at T0 right after reset
    vt.push_back('{4'h1, 1'b0, 1'b0, 3'd0, CO | MI});
    vt.push_back('{4'h1, 1'b0, 1'b0, 3'd1, RO | II | CE});
    vt.push_back('{4'h1, 1'b0, 1'b0, 3'd2, IO | MI});
    vt.push_back('{4'h1, 1'b0, 1'b0, 3'd3, RO | AI});
    vt.push_back('{4'h1, 1'b0, 1'b0, 3'd4, 16'h0000});
    vt.push_back('{4'h3, 1'b0, 1'b0, 3'd0, CO | MI});
    vt.push_back('{4'h3, 1'b0, 1'b0, 3'd1, RO | II | CE});
    vt.push_back('{4'h3, 1'b0, 1'b0, 3'd2, IO | MI});
    vt.push_back('{4'h3, 1'b0, 1'b0, 3'd3, RO | BI});
    vt.push_back('{4'h3, 1'b0, 1'b0, 3'd4, EO | AI | SU | FI_E});
    vt.push_back('{4'h7, 1'b0, 1'b1, 3'd0, CO | MI});
    vt.push_back('{4'h7, 1'b0, 1'b1, 3'd1, RO | II | CE});
    vt.push_back('{4'h7, 1'b0, 1'b1, 3'd2, 16'h0000});
    vt.push_back('{4'h7, 1'b0, 1'b1, 3'd3, 16'h0000});
    vt.push_back('{4'h7, 1'b0, 1'b1, 3'd4, 16'h0000});
    vt.push_back('{4'h7, 1'b1, 1'b0, 3'd0, CO | MI});
    vt.push_back('{4'h7, 1'b1, 1'b0, 3'd1, RO | II | CE});
    vt.push_back('{4'h7, 1'b1, 1'b0, 3'd2, JC_E});
    vt.push_back('{4'h7, 1'b1, 1'b0, 3'd3, 16'h0000});
    vt.push_back('{4'h4, 1'b0, 1'b0, 3'd4, 16'h0000});
    vt.push_back('{4'h4, 1'b0, 1'b0, 3'd0, CO | MI});
    vt.push_back('{4'h4, 1'b0, 1'b0, 3'd1, RO | II | CE});
    vt.push_back('{4'h4, 1'b0, 1'b0, 3'd2, IO | MI});
    vt.push_back('{4'h4, 1'b0, 1'b0, 3'd3, AO | RI});
    vt.push_back('{4'hE, 1'b0, 1'b0, 3'd4, 16'h0000});
    vt.push_back('{4'hE, 1'b0, 1'b0, 3'd0, CO | MI});
    vt.push_back('{4'hE, 1'b0, 1'b0, 3'd1, RO | II | CE});
    vt.push_back('{4'hE, 1'b0, 1'b0, 3'd2, AO | OI});
    vt.push_back('{4'hB, 1'b0, 1'b0, 3'd3, 16'h0000});
    vt.push_back('{4'h1, 1'b0, 1'b0, 3'd4, 16'h0000});
    vt.push_back('{4'h1, 1'b0, 1'b0, 3'd0, CO | MI});

    opcode = 4'h0;
    flag_c = 1'b0;
    flag_z = 1'b0;
    clear  = 1'b1;
    #2;
    chk("reset_step", {13'd0, step5}, 16'd0);
    chk("reset_word", w5, 16'h0000);
    do_reset();

    // vector table
    foreach (vt[i]) begin
      opcode = vt[i].op;
      flag_c = vt[i].fc;
      flag_z = vt[i].fz;
      #2;
      chk($sformatf("vec%0d_step", i), {13'd0, step5}, {13'd0, vt[i].st});
      chk($sformatf("vec%0d_word", i), w5, vt[i].w);
      cyc();
    end

    // clear in the middle of ADD T3
    do_reset();
    opcode = 4'h2;
    cyc(); cyc(); cyc();
    #2;
    chk("add_t3_word", w5, RO | BI);
    set_clear(1'b1);
    #1;
    chk("midclr_step", {13'd0, step5}, 16'd0);
    chk("midclr_word", w5, 16'h0000);
    cyc();
    check_model("clr_held");
    set_clear(1'b0);
    #2;
    chk("rel_step", {13'd0, step5}, 16'd0);
    chk("rel_word", w5, CO | MI);
    cyc();
    check_model("rel_t1");

    // HLT freeze and exit by clear only
    do_reset();
    opcode = 4'hF;
    cyc(); cyc();
    #2;
    chk("hlt_asserted", {15'd0, hlt5}, 16'd1);
    for (int k = 0; k < 20; k++) begin
      cyc();
      chk($sformatf("hlt_hold%0d", k), {13'd0, step5}, 16'd2);
    end
    set_clear(1'b1);
    #2;
    chk("hlt_clr_step", {13'd0, step5}, 16'd0);
    chk("hlt_clr_hlt", {15'd0, hlt5}, 16'd0);
    set_clear(1'b0);

    // every opcode through every step on both step counts
    for (int o = 0; o < 16; o++) begin
      for (int f = 0; f < 2; f++) begin
        do_reset();
        opcode = 4'(o);
        flag_c = f[0];
        flag_z = f[0];
        for (int s = 0; s < 6; s++) begin
          check_model($sformatf("sweep_op%0d_f%0d_s%0d", o, f, s));
          cyc();
        end
      end
    end

    // random stream including random opcode swaps and occasional resets
    do_reset();
    for (int r = 0; r < 600; r++) begin
      opcode = 4'($urandom_range(0, 15));
      flag_c = 1'($urandom_range(0, 1));
      flag_z = 1'($urandom_range(0, 1));
      set_clear($urandom_range(0, 19) == 0);
      check_model($sformatf("rnd%0d", r));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
